// File: rtl/modclk_pkg.sv
// Shared types and constants for the modulation clock reconfiguration path.
package modclk_pkg;

   localparam int FREQ_SEL_W  = 3;
   localparam int PHASE_SEL_W = 5;
   localparam int PATTERN_W   = 32;
   localparam int CNT_W       = 16;

   localparam logic [FREQ_SEL_W-1:0] FREQ_100K = 3'd0;
   localparam logic [FREQ_SEL_W-1:0] FREQ_200K = 3'd1;
   localparam logic [FREQ_SEL_W-1:0] FREQ_500K = 3'd2;
   localparam logic [FREQ_SEL_W-1:0] FREQ_1M   = 3'd3;
   localparam logic [FREQ_SEL_W-1:0] FREQ_2M   = 3'd4;
   localparam logic [FREQ_SEL_W-1:0] FREQ_4M   = 3'd5;

   typedef enum logic [2:0] {
      BOOT,
      IDLE,
      QUIESCE,
      SETTLE,
      WAIT_LOCK,
      RELEASE
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/modclk_reconfig_ctrl.sv
// Modulation clock reconfiguration sequencer.
// Optional serial pattern load enabled by MODCLK_RECONFIG_PATTERN_EN.
module modclk_reconfig_ctrl
   import modclk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int FREQ_CODES    = 6
) (
   input  logic                   USER_CLOCK,
   input  logic                   RESET_N,
   input  logic                   CFG_VALID,
   output logic                   CFG_READY,
   input  logic [FREQ_SEL_W-1:0]  CFG_FREQ_SEL,
   input  logic [PHASE_SEL_W-1:0] CFG_PHASE_SEL,
   input  logic                   CLKGEN_LOCKED,
   input  logic                   PERIOD_TICK,
   output logic [FREQ_SEL_W-1:0]  FREQ_SEL,
   output logic [PHASE_SEL_W-1:0] PHASE_SEL,
   output logic                   SR_RESET,
   output logic                   BUSY,
   output logic                   CFG_DONE,
   output logic                   CFG_ERR
`ifdef MODCLK_RECONFIG_PATTERN_EN
   ,
   input  logic [PATTERN_W-1:0]   CFG_PATTERN,
   output logic                   SR_LOAD_DATA,
   output logic                   SR_LOAD_STB
`endif
);

`ifdef MODCLK_RECONFIG_PATTERN_EN
   localparam int SETTLE_LEN = max_int(SETTLE_CYCLES, PATTERN_W);
`else
   localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LEN - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT);

   logic lock_s, accept, launch;
   logic bad_code, same_code, same_pat;

   state_e                 state_q, state_d;
   logic [FREQ_SEL_W-1:0]  freq_q, freq_d;
   logic [FREQ_SEL_W-1:0]  req_freq_q, req_freq_d;
   logic [PHASE_SEL_W-1:0] phase_q, phase_d;
   logic [PHASE_SEL_W-1:0] req_phase_q, req_phase_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic sr_q, sr_d, busy_q, busy_d;
   logic ready_q, ready_d, done_q, done_d;
   logic err_q, err_d, pend_q, pend_d;

   sync_2ff u_lock_sync (
      .clk_i  (USER_CLOCK),
      .rst_ni (RESET_N),
      .d_i    (CLKGEN_LOCKED),
      .q_o    (lock_s)
   );

   assign accept    = CFG_VALID & ready_q & lock_s;
   assign launch    = (state_q == QUIESCE) & PERIOD_TICK;
   assign bad_code  = int'(req_freq_q) >= FREQ_CODES;
   assign same_code = (req_freq_q == freq_q)
                    & (req_phase_q == phase_q) & same_pat;

   always_comb begin
      state_d     = state_q;
      freq_d      = freq_q;
      phase_d     = phase_q;
      req_freq_d  = req_freq_q;
      req_phase_d = req_phase_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      err_d       = err_q;
      pend_d      = pend_q;
      unique case (state_q)
         BOOT: begin
            sr_d    = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            if (lock_s && PERIOD_TICK) begin
               state_d = IDLE;
               sr_d    = 1'b0;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
         end
         IDLE: begin
            if (!lock_s) begin
               state_d = BOOT;
               sr_d    = 1'b1;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               pend_d  = 1'b0;
            end else if (pend_q) begin
               // decide on the captured request one cycle after the transfer
               pend_d = 1'b0;
               if (bad_code) begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else if (same_code) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  state_d = QUIESCE;
               end
            end else if (accept) begin
               pend_d      = 1'b1;
               err_d       = 1'b0;
               busy_d      = 1'b1;
               ready_d     = 1'b0;
               req_freq_d  = CFG_FREQ_SEL;
               req_phase_d = CFG_PHASE_SEL;
            end
         end
         QUIESCE: begin
            if (PERIOD_TICK) begin
               state_d = SETTLE;
               sr_d    = 1'b1;
               freq_d  = req_freq_q;
               phase_d = req_phase_q;
               cnt_d   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = WAIT_LOCK;
               cnt_d   = LOCK_LOAD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = RELEASE;
            end else if (cnt_q == '0) begin
               state_d = BOOT;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RELEASE: begin
            if (PERIOD_TICK) begin
               state_d = IDLE;
               sr_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= BOOT;
         freq_q      <= FREQ_100K;
         phase_q     <= '0;
         req_freq_q  <= '0;
         req_phase_q <= '0;
         cnt_q       <= '0;
         sr_q        <= 1'b1;
         busy_q      <= 1'b1;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         freq_q      <= freq_d;
         phase_q     <= phase_d;
         req_freq_q  <= req_freq_d;
         req_phase_q <= req_phase_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
      end
   end

`ifdef MODCLK_RECONFIG_PATTERN_EN
   logic [PATTERN_W-1:0] req_pat_q, cur_pat_q;
   logic [PATTERN_W-1:0] shreg_q, shreg_d;
   logic [4:0]           bitcnt_q, bitcnt_d;
   logic ld_data_q, ld_data_d, ld_stb_q, ld_stb_d;

   assign same_pat = (req_pat_q == cur_pat_q);

   // first bit leaves on the launch edge, the remaining 31 during SETTLE
   always_comb begin
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      ld_data_d = 1'b0;
      ld_stb_d  = 1'b0;
      if (launch) begin
         ld_data_d = req_pat_q[PATTERN_W-1];
         ld_stb_d  = 1'b1;
         shreg_d   = req_pat_q << 1;
         bitcnt_d  = 5'(PATTERN_W - 1);
      end else if (state_q == SETTLE && bitcnt_q != '0) begin
         ld_data_d = shreg_q[PATTERN_W-1];
         ld_stb_d  = 1'b1;
         shreg_d   = shreg_q << 1;
         bitcnt_d  = bitcnt_q - 5'd1;
      end
   end

   always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         req_pat_q <= '0;
         cur_pat_q <= '0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         ld_data_q <= 1'b0;
         ld_stb_q  <= 1'b0;
      end else begin
         if (accept) req_pat_q <= CFG_PATTERN;
         if (launch) cur_pat_q <= req_pat_q;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         ld_data_q <= ld_data_d;
         ld_stb_q  <= ld_stb_d;
      end
   end

   assign SR_LOAD_DATA = ld_data_q;
   assign SR_LOAD_STB  = ld_stb_q;
`else
   assign same_pat = 1'b1;
`endif

   assign CFG_READY = ready_q;
   assign FREQ_SEL  = freq_q;
   assign PHASE_SEL = phase_q;
   assign SR_RESET  = sr_q;
   assign BUSY      = busy_q;
   assign CFG_DONE  = done_q;
   assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_modclk_reconfig_ctrl.sv
// Randomized bench for modclk_reconfig_ctrl against a request-level model.
module tb_modclk_reconfig_ctrl;
   import modclk_pkg::*;

   localparam int SETTLE = 16;
   localparam int TMO    = 100;
   localparam int TICK_P = 40;

   logic       USER_CLOCK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       CFG_VALID = 1'b0;
   logic       CLKGEN_LOCKED = 1'b0;
   logic       PERIOD_TICK = 1'b0;
   logic [2:0] CFG_FREQ_SEL = '0;
   logic [4:0] CFG_PHASE_SEL = '0;
   logic       CFG_READY, SR_RESET, BUSY, CFG_DONE, CFG_ERR;
   logic [2:0] FREQ_SEL;
   logic [4:0] PHASE_SEL;
`ifdef MODCLK_RECONFIG_PATTERN_EN
   logic [31:0] CFG_PATTERN = '0;
   logic        SR_LOAD_DATA, SR_LOAD_STB;
`endif

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [2:0] m_freq;
   logic [4:0] m_phase;
   logic       m_err;

   modclk_reconfig_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .LOCK_TIMEOUT  (TMO),
      .FREQ_CODES    (6)
   ) dut (
      .USER_CLOCK    (USER_CLOCK),
      .RESET_N       (RESET_N),
      .CFG_VALID     (CFG_VALID),
      .CFG_READY     (CFG_READY),
      .CFG_FREQ_SEL  (CFG_FREQ_SEL),
      .CFG_PHASE_SEL (CFG_PHASE_SEL),
      .CLKGEN_LOCKED (CLKGEN_LOCKED),
      .PERIOD_TICK   (PERIOD_TICK),
      .FREQ_SEL      (FREQ_SEL),
      .PHASE_SEL     (PHASE_SEL),
      .SR_RESET      (SR_RESET),
      .BUSY          (BUSY),
      .CFG_DONE      (CFG_DONE),
      .CFG_ERR       (CFG_ERR)
`ifdef MODCLK_RECONFIG_PATTERN_EN
      ,
      .CFG_PATTERN   (CFG_PATTERN),
      .SR_LOAD_DATA  (SR_LOAD_DATA),
      .SR_LOAD_STB   (SR_LOAD_STB)
`endif
   );

   always #5 USER_CLOCK = ~USER_CLOCK;

   always @(posedge USER_CLOCK) cyc <= cyc + 1;

   // free-running modulation period, changed on the falling edge
   initial begin
      int tc;
      tc = 0;
      forever begin
         @(negedge USER_CLOCK);
         tc = (tc == TICK_P - 1) ? 0 : tc + 1;
         PERIOD_TICK = (tc == 0);
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge USER_CLOCK);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (CFG_READY !== 1'b1 && n < 5 * TICK_P) begin
         step();
         n++;
      end
      ok = (CFG_READY === 1'b1);
   endtask

   task automatic wait_boot(input string tag);
      bit ok;
      wait_ready(ok);
      chk({tag, "_rdy"}, CFG_READY, 1);
      chk({tag, "_tick"}, PERIOD_TICK, 1);
      chk({tag, "_sr"}, SR_RESET, 0);
      chk({tag, "_busy"}, BUSY, 0);
   endtask

   task automatic req(input logic [2:0] f, input logic [4:0] p,
                      input bit drop);
      bit bad, same, ok, saw_done;
      int n;
      bad  = (f >= 3'd6);
      same = !bad && f == m_freq && p == m_phase;
      wait_ready(ok);
      if (!ok) begin
         chk("req_ready", CFG_READY, 1);
         return;
      end
      CFG_VALID     = 1'b1;
      CFG_FREQ_SEL  = f;
      CFG_PHASE_SEL = p;
      step();
      CFG_VALID     = 1'b0;
      CFG_FREQ_SEL  = 3'($urandom);
      CFG_PHASE_SEL = 5'($urandom);
      m_err = 1'b0;
      chk("acc_busy", BUSY, 1);
      chk("acc_ready", CFG_READY, 0);
      chk("acc_err", CFG_ERR, 0);
      if (bad) begin
         step();
         m_err = 1'b1;
         chk("bad_err", CFG_ERR, 1);
         chk("bad_busy", BUSY, 0);
         chk("bad_ready", CFG_READY, 1);
         chk("bad_freq", FREQ_SEL, m_freq);
         chk("bad_sr", SR_RESET, 0);
      end else if (same) begin
         step();
         chk("same_done", CFG_DONE, 1);
         chk("same_sr", SR_RESET, 0);
         chk("same_ready", CFG_READY, 1);
         chk("same_freq", FREQ_SEL, m_freq);
         step();
         chk("same_pulse", CFG_DONE, 0);
      end else begin
         n = 0;
         while (SR_RESET === 1'b0 && n < 3 * TICK_P) begin
            step();
            n++;
         end
         if (SR_RESET !== 1'b1) begin
            chk("sw_start", SR_RESET, 1);
            return;
         end
         chk("sw_on_tick", PERIOD_TICK, 1);
         chk("sw_freq", FREQ_SEL, f);
         chk("sw_phase", PHASE_SEL, p);
         chk("sw_busy", BUSY, 1);
         m_freq  = f;
         m_phase = p;
         if (drop) begin
            CLKGEN_LOCKED = 1'b0;
            n = 0;
            while (CFG_ERR !== 1'b1 && n < SETTLE + TMO + 20) begin
               step();
               n++;
            end
            m_err = 1'b1;
            chk("tmo_err", CFG_ERR, 1);
            chk("tmo_window",
                (n >= SETTLE + TMO - 1 && n <= SETTLE + TMO + 3), 1);
            chk("tmo_sr", SR_RESET, 1);
            chk("tmo_ready", CFG_READY, 0);
            chk("tmo_freq", FREQ_SEL, m_freq);
            step();
            CLKGEN_LOCKED = 1'b1;
            wait_boot("tmo_boot");
            chk("tmo_sticky", CFG_ERR, m_err);
         end else begin
            n = 0;
            saw_done = 1'b0;
            while (SR_RESET === 1'b1 && n < SETTLE + 3 * TICK_P) begin
               step();
               n++;
               if (SR_RESET === 1'b1 && CFG_DONE === 1'b1) saw_done = 1'b1;
            end
            chk("sr_hold", (n >= SETTLE), 1);
            chk("early_done", saw_done, 0);
            chk("rel_sr", SR_RESET, 0);
            chk("rel_on_tick", PERIOD_TICK, 1);
            chk("rel_done", CFG_DONE, 1);
            chk("rel_busy", BUSY, 0);
            chk("rel_err", CFG_ERR, m_err);
            step();
            chk("rel_pulse", CFG_DONE, 0);
         end
      end
   endtask

   initial begin
      bit ok;
      int n, t_lock;
      logic [2:0] f;
      logic [4:0] p;
      bit drop;

      #1 RESET_N = 1'b0;
      repeat (5) step();
      chk("rst_sr", SR_RESET, 1);
      chk("rst_busy", BUSY, 1);
      chk("rst_ready", CFG_READY, 0);
      chk("rst_done", CFG_DONE, 0);
      chk("rst_err", CFG_ERR, 0);
      chk("rst_freq", FREQ_SEL, 0);
      chk("rst_phase", PHASE_SEL, 0);
      RESET_N = 1'b1;
      while (cyc < 20) step();
      CLKGEN_LOCKED = 1'b1;
      t_lock = cyc;
      wait_boot("boot");
      chk("boot_after_lock", (cyc - t_lock >= 2), 1);
      m_freq  = '0;
      m_phase = '0;
      m_err   = 1'b0;

      req(3'd3, 5'd7, 1'b0);
      req(3'd3, 5'd7, 1'b0);
      req(3'd6, 5'd2, 1'b0);
      req(3'd7, 5'd7, 1'b0);
      req(3'd5, 5'd1, 1'b1);

      // lock loss while idle reboots without raising an error
      step();
      CLKGEN_LOCKED = 1'b0;
      n = 0;
      while (SR_RESET !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("ll_sr", SR_RESET, 1);
      chk("ll_latency", (n <= 4), 1);
      chk("ll_ready", CFG_READY, 0);
      chk("ll_err", CFG_ERR, m_err);
      step();
      CLKGEN_LOCKED = 1'b1;
      wait_boot("ll_boot");

      // asynchronous reset in the middle of SETTLE
      f = (m_freq == 3'd2) ? 3'd4 : 3'd2;
      wait_ready(ok);
      CFG_VALID = 1'b1;
      CFG_FREQ_SEL = f;
      CFG_PHASE_SEL = 5'd9;
      step();
      CFG_VALID = 1'b0;
      n = 0;
      while (SR_RESET !== 1'b1 && n < 3 * TICK_P) begin
         step();
         n++;
      end
      chk("ar_started", SR_RESET, 1);
      repeat (5) step();
      #2 RESET_N = 1'b0;
      #1;
      chk("ar_sr", SR_RESET, 1);
      chk("ar_busy", BUSY, 1);
      chk("ar_ready", CFG_READY, 0);
      chk("ar_done", CFG_DONE, 0);
      chk("ar_err", CFG_ERR, 0);
      chk("ar_freq", FREQ_SEL, 0);
      chk("ar_phase", PHASE_SEL, 0);
      step();
      RESET_N = 1'b1;
      m_freq  = '0;
      m_phase = '0;
      m_err   = 1'b0;
      wait_boot("ar_boot");
      req(3'd1, 5'd3, 1'b0);

      for (int i = 0; i < 20; i++) begin
         f = 3'($urandom_range(0, 7));
         p = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            f = m_freq;
            p = m_phase;
         end
         drop = ($urandom_range(0, 7) == 0);
         req(f, p, drop);
         repeat ($urandom_range(0, 5)) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/modclk_reconfig_ctrl.md
Name: modclk_reconfig_ctrl

Overview:
- Sequences run-time reconfiguration of the modulation clock path: clock-generator frequency select, frequency mux and non-overlap shift-register phase generator.
- Accepts one frequency/phase request via valid/ready and holds the shift register in reset across the switch.
- Switches the mux only at a modulation-period boundary, waits for clock-generator lock, then releases the shift register on the next boundary.
- Sits between the host/config interface and the clock-generation datapath.

Parameters:
- SETTLE_CYCLES, 16: USER_CLOCK cycles that SR_RESET is held after the new selects are driven, before lock is sampled.
- LOCK_TIMEOUT, 65535: max USER_CLOCK cycles in WAIT_LOCK before abort.
- FREQ_CODES, 6: number of legal FREQ_SEL codes (0..5 = 100k, 200k, 500k, 1M, 2M, 4M).

Ports:
- USER_CLOCK, input, 1: sole clock.
- RESET_N, input, 1: asynchronous, active-low reset.
- CFG_VALID, input, 1: request valid.
- CFG_READY, output, 1: controller can accept a request.
- CFG_FREQ_SEL, input, 3: requested frequency code.
- CFG_PHASE_SEL, input, 5: requested phase code.
- CLKGEN_LOCKED, input, 1: clock-generator lock; asynchronous, synchronized internally.
- PERIOD_TICK, input, 1: single-cycle pulse in the USER_CLOCK domain, once per modulation period.
- FREQ_SEL, output, 3: drives the frequency mux select.
- PHASE_SEL, output, 5: drives the shift-register phase select.
- SR_RESET, output, 1: active-high reset to the shift register.
- BUSY, output, 1: reconfiguration in progress.
- CFG_DONE, output, 1: one-cycle pulse on successful completion.
- CFG_ERR, output, 1: sticky; set on bad code or lock timeout; cleared on the next accepted request.

Behaviour:
- Reset values:
  - FREQ_SEL = 0, PHASE_SEL = 0.
  - SR_RESET = 1, BUSY = 1, CFG_READY = 0, CFG_DONE = 0, CFG_ERR = 0.
  - State = BOOT.
- CLKGEN_LOCKED passes through a 2-flop synchronizer (LOCK_S), giving 2 cycles of latency. PERIOD_TICK is used unsynchronized.
- All outputs are registered.
- CFG_READY = 1 only in IDLE. A transfer occurs on CFG_VALID & CFG_READY. Request fields are captured on that edge, and CFG_READY drops the next cycle.
- States:
  - BOOT: SR_RESET = 1. On LOCK_S = 1 and PERIOD_TICK, go to IDLE with SR_RESET = 0 and BUSY = 0.
  - IDLE: on transfer, clear CFG_ERR and set BUSY = 1.
    - If the captured frequency code is >= FREQ_CODES: set CFG_ERR, stay in IDLE, leave outputs unchanged, BUSY = 0 the next cycle.
    - If the frequency and phase codes both equal the current FREQ_SEL/PHASE_SEL: pulse CFG_DONE the next cycle, stay in IDLE, no reset.
    - Otherwise go to QUIESCE.
  - QUIESCE: wait for PERIOD_TICK. On the tick, assert SR_RESET = 1, drive FREQ_SEL/PHASE_SEL with the new values (same edge), load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
  - SETTLE: decrement the counter. At 0, load the timeout counter with LOCK_TIMEOUT and go to WAIT_LOCK.
  - WAIT_LOCK:
    - LOCK_S = 1: go to RELEASE.
    - Counter reaches 0 without lock: set CFG_ERR and go to BOOT (SR_RESET stays 1, selects keep the new value).
  - RELEASE: on PERIOD_TICK, set SR_RESET = 0, pulse CFG_DONE for 1 cycle, BUSY = 0, go to IDLE.
- Loss of lock in IDLE (LOCK_S falls): assert SR_RESET, go to BOOT. CFG_ERR is not set.
- PERIOD_TICK in the same cycle as the transfer: ignored. QUIESCE waits for the next tick, so minimum latency is 1 tick.
- CFG_VALID while not ready: no effect. The requester must hold its request until ready.
- RESET_N asserted mid-sequence: all state and outputs return to reset values immediately (asynchronously). The in-flight request is lost.
- Counters are 16 bits wide with no wrap: they saturate at 0.

Optional Feature:
- Macro: MODCLK_RECONFIG_PATTERN_EN.
- When defined:
  - Adds input CFG_PATTERN[31:0], captured with the request.
  - Adds outputs SR_LOAD_DATA (1), SR_LOAD_STB (1).
  - During SETTLE, the pattern is shifted out MSB-first, one bit per cycle with SR_LOAD_STB = 1, for 32 cycles. SETTLE lasts max(SETTLE_CYCLES, 32) cycles.
  - A same-code request with a different pattern is not a no-op; it runs the full sequence.
- When not defined: no pattern ports and no shifter; SETTLE lasts exactly SETTLE_CYCLES.

Decomposition:
- Package modclk_pkg:
  - state enum (BOOT, IDLE, QUIESCE, SETTLE, WAIT_LOCK, RELEASE).
  - FREQ_SEL_W = 3, PHASE_SEL_W = 5, PATTERN_W = 32.
  - Named frequency-code constants FREQ_100K..FREQ_4M.
- Sub-module sync_2ff, a reusable 2-flop synchronizer with async active-low reset, used for CLKGEN_LOCKED.

Test Plan:
- Boot: RESET_N low 5 cycles; LOCKED high at cycle 20; tick every 40 cycles -> SR_RESET falls and BUSY falls on the first tick after LOCK_S; CFG_READY = 1.
- Normal switch: request freq 3, phase 7, with LOCKED held high -> FREQ_SEL = 3 and PHASE_SEL = 7 on the next tick edge with SR_RESET = 1; SR_RESET held >= 16 cycles; CFG_DONE pulse on the following tick; SR_RESET = 0.
- Bad code: request freq 6 -> CFG_ERR = 1, FREQ_SEL unchanged, no SR_RESET, CFG_READY back to 1 within 2 cycles.
- Lock timeout: LOCK_TIMEOUT = 100; drop LOCKED permanently after the switch -> CFG_ERR = 1 after 100 cycles in WAIT_LOCK; state BOOT; SR_RESET stays 1.
- Same-code request: repeat freq 3, phase 7 -> CFG_DONE the next cycle, SR_RESET never asserted.
- Async reset asserted in SETTLE -> all outputs at reset values in the same cycle; new request is accepted after reboot.
